// File: rtl/softmax_row_max_sub.sv
// Softmax stage 1: captures a row, finds its maximum, then streams
// saturated x[k] - max with a valid/ready handshake.
module softmax_row_max_sub #(
    parameter int N    = 32,
    parameter int W    = 16,
    parameter int IDXW = $clog2(N)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic signed [W-1:0]    i_row [N-1:0],
    input  logic                   i_ready,
    output logic                   o_valid,
    output logic signed [W-1:0]    o_data,
    output logic [IDXW-1:0]        o_idx,
    output logic                   o_last,
    output logic signed [W-1:0]    o_max,
    output logic                   o_busy,
    output logic                   o_done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_MAX,
        S_SUB,
        S_DONE
    } state_t;

    localparam logic [IDXW-1:0] LAST = IDXW'(N - 1);

    state_t                r_state;
    logic [IDXW-1:0]       r_cnt;
    logic signed [W-1:0]   r_buf [N-1:0];
    logic signed [W-1:0]   r_max;

    logic signed [W-1:0]   w_cur;
    logic signed [W:0]     w_diff;
    logic signed [W-1:0]   w_sat;
    logic                  w_sub;
    logic                  w_xfer;
    logic                  w_at_last;

    assign w_cur     = r_buf[r_cnt];
    assign w_diff    = {w_cur[W-1], w_cur} - {r_max[W-1], r_max};
    // w_diff is never positive, so only the negative bound can overflow
    assign w_sat     = (w_diff[W] && !w_diff[W-1]) ?
                       {1'b1, {(W-1){1'b0}}} : w_diff[W-1:0];
    assign w_sub     = (r_state == S_SUB);
    assign w_xfer    = w_sub && i_ready;
    assign w_at_last = (r_cnt == LAST);

    assign o_valid = w_sub;
    assign o_data  = w_sub ? w_sat : '0;
    assign o_idx   = w_sub ? r_cnt : '0;
    assign o_last  = w_sub && w_at_last;
    assign o_max   = r_max;
    assign o_busy  = (r_state != S_IDLE);
    assign o_done  = (r_state == S_DONE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_max   <= '0;
            for (int k = 0; k < N; k++) begin
                r_buf[k] <= '0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        for (int k = 0; k < N; k++) begin
                            r_buf[k] <= i_row[k];
                        end
                        r_max   <= i_row[0];
                        r_cnt   <= IDXW'(1);
                        r_state <= S_MAX;
                    end
                end
                S_MAX: begin
                    if (w_cur > r_max) begin
                        r_max <= w_cur;
                    end
                    if (w_at_last) begin
                        r_cnt   <= '0;
                        r_state <= S_SUB;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SUB: begin
                    if (w_xfer) begin
                        if (w_at_last) begin
                            r_state <= S_DONE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_softmax_row_max_sub.sv
// Directed bench for softmax_row_max_sub: latency, data, saturation,
// backpressure, ignored restarts and mid-operation reset.
module tb_softmax_row_max_sub;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic signed [15:0] row [31:0];
    logic               ready;
    logic               valid;
    logic signed [15:0] data;
    logic [4:0]         idx;
    logic               last;
    logic signed [15:0] maxv;
    logic               busy;
    logic               done;

    int n_chk;
    int n_err;
    int exp_d [32];

    softmax_row_max_sub dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .i_start (start),
        .i_row   (row),
        .i_ready (ready),
        .o_valid (valid),
        .o_data  (data),
        .o_idx   (idx),
        .o_last  (last),
        .o_max   (maxv),
        .o_busy  (busy),
        .o_done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Pulse start at a negedge; returns at the negedge after the sample edge
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: ready=1, 1: backpressure, 2: restart pulses in MAX and SUB
    task automatic run_row(input int mode, input int exp_max);
        int w;
        int k;
        int st;
        int budget;
        bit alt;
        bit rdy;
        bit inj;
        w = 0;
        while (!valid && w < 100) begin
            if (mode == 2 && w == 10) begin
                for (int i = 0; i < 32; i++) row[i] = 16'sd1000;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            w++;
            if (mode == 2) check("busy_max", int'(busy), 1);
        end
        start = 1'b0;
        check("latency", w, 31);
        check("max", int'(maxv), exp_max);
        k = 0;
        st = 0;
        alt = 1'b1;
        inj = 1'b0;
        budget = 0;
        while (k < 32 && budget < 200) begin
            rdy = 1'b1;
            if (mode == 1) begin
                if (k == 10 && st < 5) begin
                    rdy = 1'b0;
                    st++;
                end else if (k > 10) begin
                    rdy = alt;
                    alt = !alt;
                end
            end
            start = (mode == 2 && k == 5 && !inj);
            if (start) inj = 1'b1;
            ready = rdy;
            check("valid", int'(valid), 1);
            check("idx", int'(idx), k);
            check("data", int'(data), exp_d[k]);
            check("last", int'(last), (k == 31) ? 1 : 0);
            check("done_early", int'(done), 0);
            if (mode == 2) check("busy_sub", int'(busy), 1);
            if (rdy) k++;
            @(negedge clk);
            budget++;
        end
        start = 1'b0;
        ready = 1'b1;
        check("all_xfer", k, 32);
        check("done", int'(done), 1);
        check("valid_done", int'(valid), 0);
        check("max_hold", int'(maxv), exp_max);
        @(negedge clk);
        check("done_pulse", int'(done), 0);
        check("idle", int'(busy), 0);
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        rst_n = 1'b0;
        start = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 32; i++) row[i] = 16'sd0;
        #12;
        check("rst_valid", int'(valid), 0);
        check("rst_data", int'(data), 0);
        check("rst_max", int'(maxv), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;

        // Ascending row
        for (int i = 0; i < 32; i++) begin
            row[i] = 16'(i);
            exp_d[i] = i - 31;
        end
        pulse_start();
        run_row(0, 31);

        // Constant negative row
        for (int i = 0; i < 32; i++) begin
            row[i] = -16'sd5;
            exp_d[i] = 0;
        end
        pulse_start();
        run_row(0, -5);

        // Saturation
        for (int i = 0; i < 32; i++) begin
            row[i] = 16'sd0;
            exp_d[i] = -32767;
        end
        row[3] = 16'sd32767;
        row[7] = -16'sd32768;
        exp_d[3] = 0;
        exp_d[7] = -32768;
        pulse_start();
        run_row(0, 32767);

        // Backpressure
        for (int i = 0; i < 32; i++) begin
            row[i] = 16'(3 * i - 40);
            exp_d[i] = 3 * i - 40 - 53;
        end
        pulse_start();
        run_row(1, 53);

        // Restart attempts while busy
        for (int i = 0; i < 32; i++) begin
            row[i] = 16'((i % 7) * 100 - 300);
            exp_d[i] = (i % 7) * 100 - 300 - 300;
        end
        pulse_start();
        run_row(2, 300);

        // Reset during MAX at cnt 12
        for (int i = 0; i < 32; i++) row[i] = 16'(i + 50);
        pulse_start();
        repeat (11) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mrst_valid", int'(valid), 0);
        check("mrst_data", int'(data), 0);
        check("mrst_idx", int'(idx), 0);
        check("mrst_max", int'(maxv), 0);
        check("mrst_busy", int'(busy), 0);
        check("mrst_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 32; i++) begin
            row[i] = 16'(-i);
            exp_d[i] = -i;
        end
        pulse_start();
        run_row(0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/softmax_row_max_sub.md
Name: softmax_row_max_sub

Overview:
- First arithmetic stage of the 32-element softmax pipeline. Sits directly downstream of the BRAM row reader.
- Captures one full row (N signed values) when the reader signals completion, then finds the row maximum sequentially.
- Streams out x_i − max per element (saturated, always ≤ 0) with a valid/ready handshake to the exponent stage.

Parameters:
- N, 32, elements per row
- W, 16, data width (signed, two's complement)
- IDXW, $clog2(N) = 5, index counter width

Ports:
- i_clk  input  1  clock, all state updates on rising edge
- i_rst_n  input  1  asynchronous active-low reset
- i_start  input  1  one-cycle pulse, driven by the upstream reader's done; row is valid in the same cycle
- i_row  input  N×W signed  unpacked array [N-1:0], row from upstream
- i_ready  input  1  downstream accepts o_data this cycle
- o_valid  output  1  o_data/o_idx valid
- o_data  output  W signed  saturated i_row[k] − max
- o_idx  output  IDXW  element index k of o_data
- o_last  output  1  o_valid && o_idx == N−1
- o_max  output  W signed  row maximum, stable from the SUB state until the next capture
- o_busy  output  1  state != IDLE
- o_done  output  1  one-cycle pulse after the last element is accepted

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, and the row buffer, max_reg and every output are 0.
- States: IDLE, MAX, SUB, DONE.
- IDLE:
  - On i_start: buf[k] <= i_row[k] for all k; max_reg <= i_row[0]; cnt <= 1; go to MAX.
  - Without i_start: hold.
- MAX, one compare per cycle:
  - If buf[cnt] > max_reg (signed), max_reg <= buf[cnt].
  - If cnt == N−1: cnt <= 0, go to SUB. Otherwise cnt++.
  - MAX lasts exactly N−1 = 31 cycles.
- SUB:
  - o_valid = 1, o_idx = cnt.
  - o_data = sat(buf[cnt] − max_reg). The subtraction is done at W+1 bits; results below −2^(W−1) clamp to −32768. The result is never positive.
  - o_data, o_idx and o_last are combinational from registers and stay stable while i_ready = 0.
  - Handshake: an element transfers when o_valid && i_ready. On a transfer with cnt == N−1, go to DONE. Otherwise cnt++.
- DONE: o_done = 1 for one cycle, o_valid = 0, cnt <= 0, then go to IDLE.
- Latency:
  - The i_start sample edge is E0. o_valid first rises after edge E0+31, i.e. 32 cycles after the start pulse.
  - With i_ready held at 1, the last element transfers 31 cycles later and o_done is high for the cycle after that.
  - Minimum start-to-done: 64 cycles.
- i_start while not in IDLE: ignored. No capture, no state change, no error flag.
- i_start is a level sampled only in IDLE. A start held high re-triggers on the IDLE cycle after DONE.
- Ties in max: the first occurrence wins. This has no functional effect on any output.
- o_max: updates in MAX and holds in SUB, DONE and IDLE until the next capture.
- Reset mid-operation: immediate return to IDLE, outputs to 0. Partial rows are discarded and no o_done is produced.

Test Plan:
- Ascending row i_row[k] = k, i_ready = 1 → o_max = 31; o_data for k = 0..31 is −31..0; o_last at k = 31; o_valid first rises 32 cycles after i_start; o_done 1 cycle after the last transfer.
- All elements = −5 → o_max = −5; all 32 o_data = 0.
- Saturation: i_row[3] = 32767, i_row[7] = −32768, all others 0 → o_max = 32767; o_data[7] = −32768 (clamped from −65535); o_data[0] = −32767; o_data[3] = 0.
- Backpressure: i_ready = 0 for 5 cycles at k = 10, then alternating 1/0 → each element appears exactly once in order; o_data/o_idx stay stable while stalled; o_done only after the k = 31 transfer.
- i_start pulsed during MAX and during SUB with a different i_row → ignored; the output equals the first row; o_busy stays 1 throughout.
- i_rst_n asserted during MAX at cnt = 12 → all outputs 0 immediately, state IDLE; a fresh i_start then yields a correct full row and o_done.
